// File: rtl/fpu_ctrl_pkg.sv
// Shared types and encodings for the FPU issue/hazard/writeback controller.
package fpu_ctrl_pkg;

    // Controller state: idle, FPU computing, result waiting for the write port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } fpu_state_e;

    localparam logic [1:0] ALU_OP_FPU   = 2'b11;
    localparam logic [1:0] REGWRITE_INT = 2'b01;
    localparam logic [1:0] REGWRITE_FP  = 2'b10;
    localparam logic [6:0] FUNCT7_FDIV  = 7'b0001100;

endpackage

// File: rtl/fpu_hazard_cmp.sv
// Compares one register reference from ID against the pending FPU destination.
// A hit needs a live pending entry, an enabled reference, equal index and
// the same register file.
module fpu_hazard_cmp
    import fpu_ctrl_pkg::*;
(
    input  logic       pend_valid,
    input  logic [4:0] pend_rd,
    input  logic       pend_fpu,
    input  logic       cmp_en,
    input  logic [4:0] cmp_idx,
    input  logic       cmp_fpu,
    output logic       hit
);

    assign hit = pend_valid & cmp_en & (cmp_idx == pend_rd) & (cmp_fpu == pend_fpu);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue, hazard and writeback controller for the single in-flight FPU op.
// Handshake: fpu_start is a one-cycle issue pulse; the FPU result is offered
// with wb_fpu_valid and consumed in the cycle wb_fpu_commit is high, which is
// exactly when wb_fpu_valid is high and the pipeline does not own the port.
module fpu_issue_ctrl
    import fpu_ctrl_pkg::*;
#(
    parameter int FPU_LAT  = 4,
    parameter int FDIV_LAT = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       id_valid,
    input  logic [1:0] regwrite_id,
    input  logic [1:0] alu_op_id,
    input  logic [6:0] funct7_id,
    input  logic       rs1_fpu_id,
    input  logic       rs2_fpu_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic [4:0] rd_id,
    input  logic       pipe_stall,
    input  logic       flush,
    input  logic       wb_pipe_busy,
    output logic       stall_id,
    output logic       fpu_start,
    output logic       fpu_busy,
    output logic       wb_fpu_valid,
    output logic       wb_fpu_commit,
    output logic [4:0] wb_rd,
    output logic       wb_rd_fpu
);

    localparam int LAT_MAX = (FPU_LAT > FDIV_LAT) ? FPU_LAT : FDIV_LAT;
    localparam int CNT_W   = $clog2(LAT_MAX);

    fpu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd_q, rd_d;
    logic             rd_fpu_q, rd_fpu_d;

    logic fpu_op;
    logic issue;
    logic pend_valid;
    logic raw1_hit, raw2_hit, waw_hit;
    logic structural;

    assign fpu_op = id_valid & (alu_op_id == ALU_OP_FPU);

    // The entry stays pending through the commit cycle; int x0 is never a hazard.
    assign pend_valid = (state_q != ST_IDLE) & (rd_fpu_q | (rd_q != 5'd0));

    fpu_hazard_cmp u_cmp_rs1 (
        .pend_valid (pend_valid),
        .pend_rd    (rd_q),
        .pend_fpu   (rd_fpu_q),
        .cmp_en     (1'b1),
        .cmp_idx    (rs1_id),
        .cmp_fpu    (rs1_fpu_id),
        .hit        (raw1_hit)
    );

    // rs2 is compared unconditionally; a spurious match only costs a stall.
    fpu_hazard_cmp u_cmp_rs2 (
        .pend_valid (pend_valid),
        .pend_rd    (rd_q),
        .pend_fpu   (rd_fpu_q),
        .cmp_en     (1'b1),
        .cmp_idx    (rs2_id),
        .cmp_fpu    (rs2_fpu_id),
        .hit        (raw2_hit)
    );

    fpu_hazard_cmp u_cmp_rd (
        .pend_valid (pend_valid),
        .pend_rd    (rd_q),
        .pend_fpu   (rd_fpu_q),
        .cmp_en     (regwrite_id != 2'b00),
        .cmp_idx    (rd_id),
        .cmp_fpu    (regwrite_id == REGWRITE_FP),
        .hit        (waw_hit)
    );

    assign structural = fpu_op & (state_q != ST_IDLE);

    // ID stall: a flushed instruction never stalls; pipe_stall is deliberately absent.
    assign stall_id = id_valid & ~flush & (structural | raw1_hit | raw2_hit | waw_hit);

    assign issue = fpu_op & ~stall_id & ~pipe_stall & ~flush;

    assign fpu_busy  = (state_q != ST_IDLE);
    assign wb_rd     = rd_q;
    assign wb_rd_fpu = rd_fpu_q;

    // Next-state, latency counter, destination latch and handshake outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rd_d          = rd_q;
        rd_fpu_d      = rd_fpu_q;
        fpu_start     = 1'b0;
        wb_fpu_valid  = 1'b0;
        wb_fpu_commit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d   = ST_EXEC;
                    rd_d      = rd_id;
                    rd_fpu_d  = (regwrite_id == REGWRITE_FP);
                    // EXEC lasts lat-1 cycles so the result shows at issue+lat.
                    cnt_d     = (funct7_id == FUNCT7_FDIV) ? CNT_W'(FDIV_LAT - 1)
                                                           : CNT_W'(FPU_LAT - 1);
                    fpu_start = 1'b1;
                end
            end
            ST_EXEC: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_WB;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WB: begin
                wb_fpu_valid = 1'b1;
                // Pipeline writeback has priority; the result simply waits.
                if (!wb_pipe_busy) begin
                    wb_fpu_commit = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register; reset discards any in-flight op.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rd_q     <= 5'd0;
            rd_fpu_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rd_q     <= rd_d;
            rd_fpu_q <= rd_fpu_d;
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: directed scenarios with a commit scoreboard.
module tb_fpu_issue_ctrl;
    import fpu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       id_valid;
    logic [1:0] regwrite_id;
    logic [1:0] alu_op_id;
    logic [6:0] funct7_id;
    logic       rs1_fpu_id, rs2_fpu_id;
    logic [4:0] rs1_id, rs2_id, rd_id;
    logic       pipe_stall, flush, wb_pipe_busy;
    logic       stall_id, fpu_start, fpu_busy, wb_fpu_valid, wb_fpu_commit;
    logic [4:0] wb_rd;
    logic       wb_rd_fpu;

    int total = 0;
    int bad   = 0;
    logic [5:0] exp_q[$];   // {file, rd} of each commit the bench expects

    fpu_issue_ctrl #(.FPU_LAT(4), .FDIV_LAT(10)) dut (
        .clk(clk), .rstn(rstn), .id_valid(id_valid), .regwrite_id(regwrite_id),
        .alu_op_id(alu_op_id), .funct7_id(funct7_id), .rs1_fpu_id(rs1_fpu_id),
        .rs2_fpu_id(rs2_fpu_id), .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
        .pipe_stall(pipe_stall), .flush(flush), .wb_pipe_busy(wb_pipe_busy),
        .stall_id(stall_id), .fpu_start(fpu_start), .fpu_busy(fpu_busy),
        .wb_fpu_valid(wb_fpu_valid), .wb_fpu_commit(wb_fpu_commit),
        .wb_rd(wb_rd), .wb_rd_fpu(wb_rd_fpu)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard: every commit must match the oldest expected destination.
    always @(negedge clk) begin : sb_mon
        logic [5:0] e;
        if (rstn === 1'b1 && wb_fpu_commit === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_commit: unexpected commit rd=%0d fpu=%b, none expected", wb_rd, wb_rd_fpu);
            end else begin
                e = exp_q.pop_front();
                if ({wb_rd_fpu, wb_rd} !== e) begin
                    bad++;
                    $display("FAIL sb_commit: got fpu=%b rd=%0d want fpu=%b rd=%0d",
                             wb_rd_fpu, wb_rd, e[5], e[4:0]);
                end
            end
        end
    end

    // Driver tasks
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_id();
        id_valid = 0; regwrite_id = 0; alu_op_id = 0; funct7_id = 0;
        rs1_fpu_id = 0; rs2_fpu_id = 0; rs1_id = 0; rs2_id = 0; rd_id = 0;
        flush = 0; pipe_stall = 0;
    endtask

    task automatic drive_id(input logic [1:0] rw, input logic [1:0] op, input logic [6:0] f7,
                            input logic f1, input logic f2,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd);
        id_valid = 1; regwrite_id = rw; alu_op_id = op; funct7_id = f7;
        rs1_fpu_id = f1; rs2_fpu_id = f2; rs1_id = r1; rs2_id = r2; rd_id = rd;
        flush = 0; pipe_stall = 0;
    endtask

    // Steps from the issue cycle to the commit cycle, then one cycle more.
    task automatic wait_result(input int lat, input string name);
        logic ev;
        for (int k = 1; k <= lat; k++) begin
            cyc();
            if (k == 1) idle_id();
            #1;
            ev = (k == lat);
            total++;
            if (wb_fpu_valid !== ev) begin
                bad++;
                $display("FAIL %s_valid k=%0d: got %b want %b", name, k, wb_fpu_valid, ev);
            end
            if (k == lat) begin
                total++;
                if (wb_fpu_commit !== 1'b1) begin
                    bad++;
                    $display("FAIL %s_commit: got %b want 1", name, wb_fpu_commit);
                end
            end
        end
        cyc();
        #1;
        total++;
        if (fpu_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy got %b want 0", name, fpu_busy);
        end
    endtask

    task automatic test_reset();
        logic [10:0] obs;
        rstn = 0; wb_pipe_busy = 0; idle_id();
        repeat (2) @(posedge clk);
        #1;
        obs = {stall_id, fpu_start, fpu_busy, wb_fpu_valid, wb_fpu_commit, wb_rd_fpu, wb_rd};
        total++;
        if (obs !== 11'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", obs);
        end
        rstn = 1;
        cyc();
    endtask

    task automatic test_fadd();
        logic ev;
        drive_id(REGWRITE_FP, ALU_OP_FPU, 7'b0000000, 1, 1, 5'd1, 5'd2, 5'd3);
        #1;
        total++;
        if (fpu_start !== 1'b1) begin bad++; $display("FAIL fadd_start: got %b want 1", fpu_start); end
        total++;
        if (stall_id !== 1'b0) begin bad++; $display("FAIL fadd_nostall: got %b want 0", stall_id); end
        exp_q.push_back({1'b1, 5'd3});
        for (int k = 1; k <= 4; k++) begin
            cyc();
            if (k == 1) idle_id();
            #1;
            ev = (k == 4);
            total++;
            if (wb_fpu_valid !== ev) begin
                bad++;
                $display("FAIL fadd_valid k=%0d: got %b want %b", k, wb_fpu_valid, ev);
            end
            if (k == 1) begin
                total++;
                if ({fpu_start, fpu_busy} !== 2'b01) begin
                    bad++;
                    $display("FAIL fadd_pulse: start/busy got %b want 01", {fpu_start, fpu_busy});
                end
            end
        end
        total++;
        if ({wb_fpu_commit, wb_rd_fpu, wb_rd} !== {1'b1, 1'b1, 5'd3}) begin
            bad++;
            $display("FAIL fadd_wb: commit=%b fpu=%b rd=%0d want 1 1 3", wb_fpu_commit, wb_rd_fpu, wb_rd);
        end
        cyc();
        #1;
        total++;
        if ({fpu_busy, wb_fpu_valid} !== 2'b00) begin
            bad++;
            $display("FAIL fadd_idle: busy/valid got %b want 00", {fpu_busy, wb_fpu_valid});
        end
    endtask

    task automatic test_raw();
        logic es;
        logic ev;
        drive_id(REGWRITE_FP, ALU_OP_FPU, FUNCT7_FDIV, 1, 1, 5'd1, 5'd2, 5'd3);
        #1;
        total++;
        if (fpu_start !== 1'b1) begin bad++; $display("FAIL fdiv_start: got %b want 1", fpu_start); end
        exp_q.push_back({1'b1, 5'd3});
        for (int k = 1; k <= 11; k++) begin
            cyc();
            case (k)
                1: drive_id(REGWRITE_INT, 2'b00, 7'd0, 0, 0, 5'd3, 5'd0, 5'd7); // int read x3
                2: drive_id(REGWRITE_INT, 2'b00, 7'd0, 0, 1, 5'd1, 5'd3, 5'd7); // rs2 reads f3
                3: drive_id(REGWRITE_FP,  2'b00, 7'd0, 0, 0, 5'd0, 5'd0, 5'd3); // writes f3
                4: drive_id(REGWRITE_INT, 2'b00, 7'd0, 0, 0, 5'd0, 5'd0, 5'd3); // writes x3
                default: drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd3, 5'd4, 5'd5);
            endcase
            #1;
            es = (k == 2) || (k == 3) || (k >= 5 && k <= 10);
            ev = (k == 10);
            total++;
            if (stall_id !== es) begin
                bad++;
                $display("FAIL raw_stall k=%0d: got %b want %b", k, stall_id, es);
            end
            total++;
            if (wb_fpu_valid !== ev) begin
                bad++;
                $display("FAIL raw_valid k=%0d: got %b want %b", k, wb_fpu_valid, ev);
            end
            if (k == 10) begin
                total++;
                if (wb_fpu_commit !== 1'b1) begin bad++; $display("FAIL raw_commit: got %b want 1", wb_fpu_commit); end
            end
            if (k == 11) begin
                total++;
                if (fpu_start !== 1'b1) begin bad++; $display("FAIL raw_reissue: got %b want 1", fpu_start); end
                exp_q.push_back({1'b1, 5'd5});
            end
        end
        wait_result(4, "raw_fadd");
    endtask

    task automatic test_back_to_back();
        logic es;
        drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd6);
        #1;
        exp_q.push_back({1'b1, 5'd6});
        for (int k = 1; k <= 5; k++) begin
            cyc();
            drive_id(REGWRITE_FP, ALU_OP_FPU, 7'b0001000, 1, 1, 5'd1, 5'd2, 5'd8);
            #1;
            es = (k < 5);
            total++;
            if ({stall_id, fpu_start} !== {es, ~es}) begin
                bad++;
                $display("FAIL b2b k=%0d: stall/start got %b%b want %b%b", k, stall_id, fpu_start, es, ~es);
            end
            if (k == 4) begin
                total++;
                if (wb_fpu_commit !== 1'b1) begin bad++; $display("FAIL b2b_commit: got %b want 1", wb_fpu_commit); end
            end
        end
        exp_q.push_back({1'b1, 5'd8});
        wait_result(4, "b2b_fmul");
    endtask

    task automatic test_wb_busy();
        logic ev, ec;
        drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd9);
        #1;
        exp_q.push_back({1'b1, 5'd9});
        for (int k = 1; k <= 7; k++) begin
            cyc();
            if (k == 1) idle_id();
            wb_pipe_busy = (k >= 4 && k <= 6);
            #1;
            ev = (k >= 4);
            ec = (k == 7);
            total++;
            if ({wb_fpu_valid, wb_fpu_commit} !== {ev, ec}) begin
                bad++;
                $display("FAIL wbbusy k=%0d: valid/commit got %b%b want %b%b", k, wb_fpu_valid, wb_fpu_commit, ev, ec);
            end
            if (k >= 4) begin
                total++;
                if ({wb_rd_fpu, wb_rd} !== {1'b1, 5'd9}) begin
                    bad++;
                    $display("FAIL wbbusy_rd k=%0d: got fpu=%b rd=%0d want 1 9", k, wb_rd_fpu, wb_rd);
                end
            end
        end
        cyc();
        wb_pipe_busy = 0;
        #1;
        total++;
        if (fpu_busy !== 1'b0) begin bad++; $display("FAIL wbbusy_idle: got %b want 0", fpu_busy); end
    endtask

    task automatic test_x0_flush();
        logic es;
        drive_id(REGWRITE_INT, ALU_OP_FPU, 7'b1100000, 1, 0, 5'd1, 5'd0, 5'd0);
        #1;
        total++;
        if (fpu_start !== 1'b1) begin bad++; $display("FAIL x0_start: got %b want 1", fpu_start); end
        exp_q.push_back({1'b0, 5'd0});
        for (int k = 1; k <= 4; k++) begin
            cyc();
            case (k)
                1: drive_id(REGWRITE_INT, 2'b00, 7'd0, 0, 0, 5'd0, 5'd0, 5'd0);
                2: begin drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd4); flush = 1; end
                3: drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd4);
                default: idle_id();
            endcase
            #1;
            es = (k == 3);
            total++;
            if (stall_id !== es) begin
                bad++;
                $display("FAIL x0_stall k=%0d: got %b want %b", k, stall_id, es);
            end
        end
        total++;
        if ({wb_fpu_commit, wb_rd_fpu, wb_rd} !== 7'b1000000) begin
            bad++;
            $display("FAIL x0_wb: commit=%b fpu=%b rd=%0d want 1 0 0", wb_fpu_commit, wb_rd_fpu, wb_rd);
        end
        cyc();
        drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd4);
        flush = 1;
        #1;
        total++;
        if ({fpu_start, stall_id} !== 2'b00) begin
            bad++;
            $display("FAIL flush_idle: start/stall got %b want 00", {fpu_start, stall_id});
        end
        cyc();
        flush = 0;
        pipe_stall = 1;
        #1;
        total++;
        if ({fpu_busy, fpu_start, stall_id} !== 3'b000) begin
            bad++;
            $display("FAIL pipestall: busy/start/stall got %b want 000", {fpu_busy, fpu_start, stall_id});
        end
        cyc();
        idle_id();
        #1;
        total++;
        if (fpu_busy !== 1'b0) begin bad++; $display("FAIL pipestall_idle: got %b want 0", fpu_busy); end
    endtask

    task automatic test_reset_mid();
        logic [10:0] obs;
        drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd10);
        #1;
        exp_q.push_back({1'b1, 5'd10});
        cyc();
        idle_id();
        cyc();
        rstn = 0;
        #1;
        obs = {stall_id, fpu_start, fpu_busy, wb_fpu_valid, wb_fpu_commit, wb_rd_fpu, wb_rd};
        total++;
        if (obs !== 11'd0) begin
            bad++;
            $display("FAIL rstmid_outputs: got %h want 0", obs);
        end
        exp_q.delete();
        cyc();
        cyc();
        rstn = 1;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            total++;
            if ({wb_fpu_valid, wb_fpu_commit, fpu_busy} !== 3'b000) begin
                bad++;
                $display("FAIL rstmid_quiet k=%0d: valid/commit/busy got %b want 000", k,
                         {wb_fpu_valid, wb_fpu_commit, fpu_busy});
            end
        end
        drive_id(REGWRITE_FP, ALU_OP_FPU, 7'd0, 1, 1, 5'd1, 5'd2, 5'd11);
        #1;
        total++;
        if (fpu_start !== 1'b1) begin bad++; $display("FAIL rstmid_reissue: got %b want 1", fpu_start); end
        exp_q.push_back({1'b1, 5'd11});
        wait_result(4, "rstmid_fadd");
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_fadd();
        test_raw();
        test_back_to_back();
        test_wb_busy();
        test_x0_flush();
        test_reset_mid();
        repeat (2) cyc();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: %0d expected commits never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
